// File: rtl/alu_exec_unit_if.sv
// Operation request/response bundle between issue and the ALU execution unit.
// Master is the initiator, slave is the execution unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       ALU_Control;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] ALU_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    modport master (
        output req_valid,
        output ALU_Control,
        output operand_A,
        output operand_B,
        output req_tag,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  ALU_result,
        input  resp_tag,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  ALU_Control,
        input  operand_A,
        input  operand_B,
        input  req_tag,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output ALU_result,
        output resp_tag,
        output resp_err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle logic/arith ops,
// iterative 1-bit-per-cycle shifts, registered tagged response.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_exec_unit_if.slave   op,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b001000;
    localparam logic [5:0] OP_SLT = 6'b000010;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_AND = 6'b000111;
    localparam logic [5:0] OP_OR  = 6'b000110;
    localparam logic [5:0] OP_SLL = 6'b000001;
    localparam logic [5:0] OP_SRL = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic             right_q, right_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             req_ready;
    logic             resp_valid;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             is_shift;
    logic             is_srl;
    logic [SH_W-1:0]  shamt;

    assign shamt      = op.operand_B[SH_W-1:0];
    assign resp_valid = (state_q == HOLD);
    assign req_ready  = reset_n &&
                        ((state_q == IDLE) ||
                         ((state_q == HOLD) && op.resp_ready));
    assign accept     = op.req_valid && req_ready;

    assign op.req_ready  = req_ready;
    assign op.resp_valid = resp_valid;
    assign op.ALU_result = result_q;
    assign op.resp_tag   = tag_q;
    assign op.resp_err   = err_q;
    assign busy          = (state_q != IDLE);
    assign op_count      = count_q;

    // Shifts pass A through; the iteration happens in SHIFT
    always_comb begin
        alu_res  = '0;
        alu_err  = 1'b0;
        is_shift = 1'b0;
        is_srl   = 1'b0;
        unique case (op.ALU_Control)
            OP_ADD: alu_res = op.operand_A + op.operand_B;
            OP_SUB: alu_res = op.operand_A - op.operand_B;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                               $signed(op.operand_A) < $signed(op.operand_B)};
            OP_XOR: alu_res = op.operand_A ^ op.operand_B;
            OP_AND: alu_res = op.operand_A & op.operand_B;
            OP_OR:  alu_res = op.operand_A | op.operand_B;
            OP_SLL: begin
                alu_res  = op.operand_A;
                is_shift = 1'b1;
            end
            OP_SRL: begin
                alu_res  = op.operand_A;
                is_shift = 1'b1;
                is_srl   = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        tag_d    = tag_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        right_d  = right_q;
        count_d  = count_q;

        if (resp_valid && op.resp_ready) begin
            count_d = count_q + 1'b1;
        end

        unique case (state_q)
            SHIFT: begin
                result_d = right_q ? (result_q >> 1) : (result_q << 1);
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == SH_W'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (op.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept only occurs in IDLE or HOLD, so it overrides the above
        if (accept) begin
            tag_d = op.req_tag;
            err_d = alu_err;
            if (is_shift && (shamt != '0)) begin
                result_d = op.operand_A;
                cnt_d    = shamt;
                right_d  = is_srl;
                state_d  = SHIFT;
            end else begin
                result_d = alu_res;
                state_d  = HOLD;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            right_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            right_q  <= right_d;
            count_q  <= count_d;
        end
    end
endmodule
